// File: rtl/heartbeat_monitor.sv
// heartbeat_monitor: receiver-side checker for a 1-cycle heartbeat pulse every 2^N clk cycles.
// Latency: period/error pulses/locked update 1 cycle after the rise is sampled (+2 with sync).
// Backpressure: none; the input is a free-running pulse and every output is a status/event.
//
// Ports:
//   clk, nreset        clock, asynchronous active-low reset
//   hb                 heartbeat pulse input (rising edge = one pulse)
//   clr_err            synchronous clear of err_count (wins over an increment)
//   locked             high while the interval has been in-window LOCK_CNT times in a row
//   err_early          1-cycle pulse: interval shorter than 2^N-TOL
//   err_late           1-cycle pulse: no pulse within 2^N+TOL cycles
//   err_count          saturating count of early+late errors
//   period             last measured interval in cycles (saturates at 2^(N+2)-1)
//
// Optional feature macro: HEARTBEAT_MONITOR_SYNC_EN
//   Defined:   hb passes a two-flop synchronizer (may be asynchronous to clk, +2 cycles latency).
//   Undefined: hb is sampled directly and must be synchronous to clk.
module heartbeat_monitor #(
  parameter int N        = 8,
  parameter int TOL      = 2,
  parameter int LOCK_CNT = 4,
  parameter int ERRW     = 8
) (
  input  logic            clk,
  input  logic            nreset,
  input  logic            hb,
  input  logic            clr_err,
  output logic            locked,
  output logic            err_early,
  output logic            err_late,
  output logic [ERRW-1:0] err_count,
  output logic [N+1:0]    period
);

  localparam int CW = N + 2;
  localparam int GW = (LOCK_CNT < 2) ? 1 : $clog2(LOCK_CNT + 1);
  localparam logic [CW-1:0] LO      = CW'((1 << N) - TOL);
  localparam logic [CW-1:0] HI      = CW'((1 << N) + TOL);
  localparam logic [CW-1:0] HI_M1   = CW'((1 << N) + TOL - 1);
  localparam logic [GW-1:0] LOCK_V  = GW'(LOCK_CNT);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2,
    LOST    = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [GW-1:0] good_q, good_d, good_inc;
  logic [CW-1:0] cnt;
  logic [CW-1:0] measured;
  logic          hb_s, hb_q;
  logic          rise, timeout, in_win, is_early;
  logic          early_d, late_d;

  // ---------------------------------------------------------------- input sampling
`ifdef HEARTBEAT_MONITOR_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], hb};
    end
  end

  assign hb_s = sync_q[1];
`else
  assign hb_s = hb;
`endif

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      hb_q <= 1'b0;
    end else begin
      hb_q <= hb_s;
    end
  end

  // A held-high hb produces a single rise.
  assign rise = hb_s & ~hb_q;

  // ---------------------------------------------------------------- interval counter
  // cnt holds (cycles since last rise) - 1, so cnt+1 at the next rise is the interval.
  assign measured = (&cnt) ? cnt : cnt + CW'(1);

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      cnt    <= '0;
      period <= '0;
    end else if (rise) begin
      cnt    <= '0;
      period <= measured;
    end else if (!(&cnt)) begin
      cnt    <= cnt + CW'(1);
    end
  end

  // cnt passes HI-1 once per gap, so the timeout cannot repeat within one gap.
  assign timeout  = (cnt == HI_M1) && !rise;
  assign in_win   = (measured >= LO) && (measured <= HI);
  assign is_early = (measured < LO);
  assign good_inc = good_q + GW'(1);

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q   <= IDLE;
      good_q    <= '0;
      err_early <= 1'b0;
      err_late  <= 1'b0;
    end else begin
      state_q   <= state_d;
      good_q    <= good_d;
      err_early <= early_d;
      err_late  <= late_d;
    end
  end

  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    early_d = 1'b0;
    late_d  = 1'b0;
    case (state_q)
      IDLE, LOST: begin
        // First pulse after reset or loss only starts a measurement.
        if (rise) begin
          state_d = ACQUIRE;
          good_d  = '0;
        end
      end
      ACQUIRE: begin
        if (rise) begin
          if (in_win) begin
            good_d = good_inc;
            if (good_inc == LOCK_V) begin
              state_d = LOCKED;
            end
          end else if (is_early) begin
            early_d = 1'b1;
            good_d  = '0;
          end else begin
            // Stale pulse: the timeout already reported this gap.
            good_d = '0;
          end
        end else if (timeout) begin
          late_d  = 1'b1;
          state_d = LOST;
        end
      end
      LOCKED: begin
        if (rise) begin
          if (is_early) begin
            early_d = 1'b1;
            good_d  = '0;
            state_d = ACQUIRE;
          end
        end else if (timeout) begin
          late_d  = 1'b1;
          state_d = LOST;
        end
      end
      default: begin
        state_d = IDLE;
        good_d  = '0;
      end
    endcase
  end

  assign locked = (state_q == LOCKED);

  // ---------------------------------------------------------------- error counter
  // Counts on the same edge that raises the error pulse; early and late are exclusive.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      err_count <= '0;
    end else if (clr_err) begin
      err_count <= '0;
    end else if ((early_d || late_d) && !(&err_count)) begin
      err_count <= err_count + ERRW'(1);
    end
  end

endmodule

// File: tb/tb_heartbeat_monitor.sv
// tb_heartbeat_monitor: directed bench for heartbeat_monitor with N=4, TOL=2, LOCK_CNT=3, ERRW=2.
// Latency: expected responses are shifted by LAT (2 with the synchronizer build, else 0).
// Backpressure: not applicable; stimulus is a hand-placed sequence of hb pulses.
module tb_heartbeat_monitor;

`ifdef HEARTBEAT_MONITOR_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic       clk;
  logic       nreset;
  logic       hb;
  logic       clr_err;
  logic       locked;
  logic       err_early;
  logic       err_late;
  logic [1:0] err_count;
  logic [5:0] period;

  int checks;
  int failures;
  int since;
  int n_early;
  int n_late;

  heartbeat_monitor #(
    .N(4),
    .TOL(2),
    .LOCK_CNT(3),
    .ERRW(2)
  ) dut (
    .clk(clk),
    .nreset(nreset),
    .hb(hb),
    .clr_err(clr_err),
    .locked(locked),
    .err_early(err_early),
    .err_late(err_late),
    .err_count(err_count),
    .period(period)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    since++;
  endtask

  // Assert hb 'gap' cycles after the previous assertion, then wait until the DUT has
  // reacted (LAT+1 edges). clr_err is raised on the edge where the DUT sees the rise.
  task automatic pulse_after(input int gap, input logic with_clr);
    while (since < gap) step();
    hb    = 1'b1;
    since = 0;
    for (int i = 0; i <= LAT; i++) begin
      clr_err = (i == LAT) ? with_clr : 1'b0;
      step();
      hb = 1'b0;
    end
    clr_err = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    since    = 0;
    nreset   = 1'b0;
    hb       = 1'b0;
    clr_err  = 1'b0;
    step();
    step();
    chk("rst_locked", 32'(locked), 0);
    chk("rst_early", 32'(err_early), 0);
    chk("rst_late", 32'(err_late), 0);
    chk("rst_count", 32'(err_count), 0);
    chk("rst_period", 32'(period), 0);
    nreset = 1'b1;
    since  = 0;

    // ---- lock from reset
    pulse_after(16, 1'b0);
    chk("lock_p1_locked", 32'(locked), 0);
    for (int p = 2; p <= 4; p++) begin
      pulse_after(16, 1'b0);
      chk("lock_period", 32'(period), 16);
      chk("lock_no_early", 32'(err_early), 0);
      chk("lock_locked", 32'(locked), (p == 4) ? 1 : 0);
    end
    chk("lock_count", 32'(err_count), 0);

    // ---- early pulse while locked, then relock with 3 pulses
    pulse_after(12, 1'b0);
    chk("early_pulse", 32'(err_early), 1);
    chk("early_locked", 32'(locked), 0);
    chk("early_count", 32'(err_count), 1);
    chk("early_period", 32'(period), 12);
    step();
    chk("early_one_cycle", 32'(err_early), 0);
    for (int p = 1; p <= 3; p++) begin
      pulse_after(16, 1'b0);
      chk("relock_locked", 32'(locked), (p == 3) ? 1 : 0);
    end

    // ---- pulses stop: one err_late 18 cycles after the last rise
    while (since < 18 + LAT) step();
    chk("late_not_yet", 32'(err_late), 0);
    chk("late_still_locked", 32'(locked), 1);
    step();
    chk("late_pulse", 32'(err_late), 1);
    chk("late_locked", 32'(locked), 0);
    chk("late_count", 32'(err_count), 2);
    step();
    chk("late_one_cycle", 32'(err_late), 0);
    n_early = 0;
    n_late  = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      n_early += int'(err_early);
      n_late  += int'(err_late);
    end
    chk("gap_no_errors", 32'(n_early + n_late), 0);
    chk("gap_count", 32'(err_count), 2);

    // ---- resume after loss: counter saturated, 4 pulses to relock
    pulse_after(1, 1'b0);
    chk("resume_period_sat", 32'(period), 63);
    chk("resume_no_early", 32'(err_early), 0);
    for (int p = 2; p <= 4; p++) begin
      pulse_after(16, 1'b0);
      chk("resume_locked", 32'(locked), (p == 4) ? 1 : 0);
    end

    // ---- window edges
    pulse_after(14, 1'b0);
    chk("win14_locked", 32'(locked), 1);
    chk("win14_period", 32'(period), 14);
    chk("win14_no_early", 32'(err_early), 0);
    pulse_after(18, 1'b0);
    chk("win18_locked", 32'(locked), 1);
    chk("win18_period", 32'(period), 18);
    chk("win18_no_late", 32'(err_late), 0);
    pulse_after(13, 1'b0);
    chk("win13_early", 32'(err_early), 1);
    chk("win13_locked", 32'(locked), 0);
    chk("win13_count", 32'(err_count), 3);

    // ---- clear, then saturation with ERRW=2
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    chk("clr_count", 32'(err_count), 0);
    for (int e = 1; e <= 5; e++) begin
      pulse_after(10, 1'b0);
      chk("sat_early", 32'(err_early), 1);
      chk("sat_count", 32'(err_count), (e < 3) ? e : 3);
    end
    pulse_after(10, 1'b1);
    chk("clr_vs_err_pulse", 32'(err_early), 1);
    chk("clr_vs_err_count", 32'(err_count), 0);

    // ---- stuck-high hb: one good rise, then a single timeout
    while (since < 16) step();
    hb    = 1'b1;
    since = 0;
    n_early = 0;
    n_late  = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      n_early += int'(err_early);
      n_late  += int'(err_late);
    end
    hb = 1'b0;
    step();
    chk("stuck_early", 32'(n_early), 0);
    chk("stuck_late", 32'(n_late), 1);
    chk("stuck_period", 32'(period), 16);
    chk("stuck_count", 32'(err_count), 1);
    chk("stuck_locked", 32'(locked), 0);

    // ---- async reset while locked
    for (int p = 1; p <= 4; p++) begin
      pulse_after(16, 1'b0);
    end
    chk("pre_rst_locked", 32'(locked), 1);
    chk("pre_rst_count", 32'(err_count), 1);
    nreset = 1'b0;
    #1;
    chk("mid_rst_locked", 32'(locked), 0);
    chk("mid_rst_count", 32'(err_count), 0);
    chk("mid_rst_period", 32'(period), 0);
    chk("mid_rst_errs", 32'({err_early, err_late}), 0);
    step();
    nreset = 1'b1;
    since  = 0;
    for (int p = 1; p <= 4; p++) begin
      pulse_after(16, 1'b0);
      chk("reacq_locked", 32'(locked), (p == 4) ? 1 : 0);
    end
    chk("reacq_period", 32'(period), 16);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
